display_source_switcher: RTL and testbench

DISPLAY_SOURCE_SWITCHER -- requirements
Module: display_source_switcher

---
 rtl/display_source_switcher.sv | 173 +++++++++++++++++
 tb/tb_display_source_switcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_switcher.sv
`default_nettype none
// ============================================================================
// display_source_switcher
//   Debounced push-button cycling of display sources. Switches happen only at
//   frame boundaries, and the colour mux is latency-matched to the sources.
// Revision: 1.0
// ============================================================================

module display_source_switcher #(
  parameter int NUM_SRC         = 3,
  parameter int ADDR_W          = 20,
  parameter int COLOR_W         = 3,
  parameter int READ_LAT        = 1,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       change_button,
  input  logic                       frame_start,
  input  logic [ADDR_W-1:0]          display_addr,
  input  logic [NUM_SRC*COLOR_W-1:0] src_color,
  output logic [ADDR_W-1:0]          src_addr,
  output logic [NUM_SRC-1:0]         src_sel,
  output logic [COLOR_W-1:0]         display_color,
  output logic                       switch_pending
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_t;

  logic [1:0]         sync_q, sync_d;
  db_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press_evt;
  logic [SEL_W-1:0]   active_src_q, active_src_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  src_addr_q, src_addr_d;
  logic [NUM_SRC-1:0] src_sel_q, src_sel_d;
  logic [COLOR_W-1:0] display_color_q, display_color_d;
  logic [SEL_W-1:0]   sel_pipe_q [READ_LAT+1];
  logic [SEL_W-1:0]   sel_pipe_d [READ_LAT+1];
  logic               btn;

  assign btn    = sync_q[1];
  assign sync_d = {sync_q[0], change_button};

  // Debounce: the counter holds the number of consecutive matching levels
  // already observed, including the one that caused entry to the wait state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (btn) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_HELD;
          cnt_d     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        cnt_d = '0;
        if (!btn) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A press that lands while a switch is already pending is dropped.
  always_comb begin
    active_src_d = active_src_q;
    pending_d    = pending_q;
    if (frame_start && pending_q) begin
      active_src_d = (active_src_q == SEL_LAST) ? '0 : active_src_q + SEL_W'(1);
      pending_d    = 1'b0;
    end else if (press_evt) begin
      pending_d = 1'b1;
    end
  end

  // Stage 0 of the select line is aligned with src_addr; the remaining
  // READ_LAT stages track the source read latency.
  always_comb begin
    src_addr_d = display_addr;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_sel_d[k] = (active_src_q == SEL_W'(k));
    end
    sel_pipe_d[0] = active_src_q;
    for (int i = 1; i <= READ_LAT; i++) begin
      sel_pipe_d[i] = sel_pipe_q[i-1];
    end
    display_color_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_pipe_q[READ_LAT] == SEL_W'(k)) begin
        display_color_d = src_color[k*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q          <= '0;
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      active_src_q    <= '0;
      pending_q       <= 1'b0;
      src_addr_q      <= '0;
      src_sel_q       <= NUM_SRC'(1);
      display_color_q <= '0;
      for (int i = 0; i <= READ_LAT; i++) begin
        sel_pipe_q[i] <= '0;
      end
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      active_src_q    <= active_src_d;
      pending_q       <= pending_d;
      src_addr_q      <= src_addr_d;
      src_sel_q       <= src_sel_d;
      display_color_q <= display_color_d;
      for (int i = 0; i <= READ_LAT; i++) begin
        sel_pipe_q[i] <= sel_pipe_d[i];
      end
    end
  end

  assign src_addr       = src_addr_q;
  assign src_sel        = src_sel_q;
  assign display_color  = display_color_q;
  assign switch_pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_display_source_switcher.sv
`default_nettype none
// ============================================================================
// tb_display_source_switcher
//   Three DUTs (READ_LAT 0/1/4) share stimulus; a cycle-level model predicts
//   every output, plus hand-computed literal checks.
// Revision: 1.0
// ============================================================================

module tb_display_source_switcher;

  localparam int NUM_SRC = 3;
  localparam int ADDR_W  = 20;
  localparam int COLOR_W = 3;
  localparam int DEB     = 4;
  localparam int NI      = 3;
  localparam int RLS [NI] = '{0, 1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, btn, frame;
  logic [ADDR_W-1:0] daddr;

  logic [ADDR_W-1:0]  sa [NI];
  logic [NUM_SRC-1:0] ss [NI];
  logic [COLOR_W-1:0] dc [NI];
  logic               sp [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Source k returns (addr + offset_k) mod 8; at addr 123 this is {5,2,7}.
  function automatic logic [COLOR_W-1:0] col(int k, logic [ADDR_W-1:0] a);
    logic [2:0] off;
    logic [2:0] r;
    case (k)
      0:       off = 3'd4;
      1:       off = 3'd7;
      default: off = 3'd2;
    endcase
    r = a[2:0] + off;
    return r;
  endfunction

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RL = RLS[g];
      logic [ADDR_W-1:0]          src_addr;
      logic [NUM_SRC-1:0]         src_sel;
      logic [COLOR_W-1:0]         display_color;
      logic                       switch_pending;
      logic [NUM_SRC*COLOR_W-1:0] src_color;
      logic [ADDR_W-1:0]          apipe [5];
      logic [ADDR_W-1:0]          mem_addr;

      always @(posedge clk) begin
        apipe[0] <= src_addr;
        for (int i = 1; i < 5; i++) apipe[i] <= apipe[i-1];
      end

      if (RL == 0) begin : g_comb
        assign mem_addr = src_addr;
      end else begin : g_reg
        assign mem_addr = apipe[RL-1];
      end

      always_comb begin
        src_color = '0;
        for (int k = 0; k < NUM_SRC; k++) src_color[k*COLOR_W +: COLOR_W] = col(k, mem_addr);
      end

      display_source_switcher #(
        .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W),
        .READ_LAT(RL), .DEBOUNCE_CYCLES(DEB)
      ) u_dut (
        .sysclk(clk), .reset(rst), .change_button(btn), .frame_start(frame),
        .display_addr(daddr), .src_color(src_color), .src_addr(src_addr),
        .src_sel(src_sel), .display_color(display_color), .switch_pending(switch_pending)
      );

      assign sa[g] = src_addr;
      assign ss[g] = src_sel;
      assign dc[g] = display_color;
      assign sp[g] = switch_pending;
    end
  endgenerate

  // Behavioural model: run-length debounce, pending flag, history of
  // (active source, address) per cycle for the colour pipeline.
  int                cyc = 0;
  bit                m_seen = 0;
  int                valid_start = 0;
  logic [ADDR_W-1:0] addr_h [4096];
  int                act_h  [4096];
  int                m_act = 0;
  bit                m_pend = 0;
  bit                d0 = 0, d1 = 0, s, press;
  int                hi = 0, lo = 0;
  bit                armed = 1;
  logic [ADDR_W-1:0] e_addr;
  logic [NUM_SRC-1:0] e_sel;
  bit                e_pend, e_rst1;
  int                n;

  always @(posedge clk) begin
    n = cyc;
    if (rst) begin
      m_act = 0; m_pend = 0; d0 = 0; d1 = 0; hi = 0; lo = 0; armed = 1;
      e_addr = '0; e_sel = 3'b001; e_pend = 0; e_rst1 = 1;
      valid_start = n + 1; m_seen = 1;
    end else begin
      s = d1; d1 = d0; d0 = btn;
      if (s) begin hi++; lo = 0; end else begin lo++; hi = 0; end
      press = 0;
      if (armed && hi == DEB) begin press = 1; armed = 0; end
      if (!armed && lo == DEB) armed = 1;
      act_h[n % 4096]  = m_act;
      addr_h[n % 4096] = daddr;
      e_addr = daddr;
      e_sel  = 3'(1 << m_act);
      if (frame && m_pend) begin
        m_act  = (m_act + 1) % NUM_SRC;
        m_pend = 0;
      end else if (press) begin
        m_pend = 1;
      end
      e_pend = m_pend; e_rst1 = 0;
    end
    cyc = n + 1;
  end

  int k;
  always @(negedge clk) begin
    if (m_seen) begin
      for (int i = 0; i < NI; i++) begin
        chk("src_addr", i, 32'(sa[i]), 32'(e_addr));
        chk("src_sel", i, 32'(ss[i]), 32'(e_sel));
        chk("switch_pending", i, 32'(sp[i]), 32'(e_pend));
        k = cyc - RLS[i] - 2;
        if (e_rst1) chk("display_color_rst", i, 32'(dc[i]), 32'd0);
        else if (k >= valid_start)
          chk("display_color", i, 32'(dc[i]), 32'(col(act_h[k % 4096], addr_h[k % 4096])));
      end
    end
  end

  task automatic tick(int cnt = 1);
    repeat (cnt) begin
      @(posedge clk); #1;
      daddr = daddr + 1'b1;
    end
  endtask

  task automatic clean_press();
    btn = 1; tick(6);
    btn = 0; tick(10);
  endtask

  task automatic frame_pulse();
    frame = 1; tick(1);
    frame = 0; tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int t;
  initial begin
    rst = 1; btn = 0; frame = 0; daddr = '0;
    tick(3);
    rst = 0;
    #5;
    for (int i = 0; i < NI; i++) begin
      chk("lit_reset_sel", i, 32'(ss[i]), 32'd1);
      chk("lit_reset_pend", i, 32'(sp[i]), 32'd0);
      chk("lit_reset_addr", i, 32'(sa[i]), 32'd0);
      chk("lit_reset_color", i, 32'(dc[i]), 32'd0);
    end

    // Pipeline latency with address 123 (source 0 returns 7)
    tick(2);
    daddr = 20'd123; t = cyc;
    tick(1); #5; chk("lit_src_addr_t1", 1, 32'(sa[1]), 32'd123);
    tick(1); #5; chk("lit_color_rl0_t2", 0, 32'(dc[0]), 32'd7);
    tick(1); #5; chk("lit_color_rl1_t3", 1, 32'(dc[1]), 32'd7);
    tick(3); #5; chk("lit_color_rl4_t6", 2, 32'(dc[2]), 32'd7);

    // Bounce: 3 high, 1 low, 3 high must not register
    tick(1);
    btn = 1; tick(3);
    btn = 0; tick(1);
    btn = 1; tick(3);
    btn = 0; tick(10);
    #5; chk("lit_bounce_no_pend", 1, 32'(sp[1]), 32'd0);

    // Clean press, then frame-aligned wrap 001->010->100->001
    btn = 1; tick(6);
    btn = 0; tick(3);
    #5; chk("lit_press_pend", 1, 32'(sp[1]), 32'd1);
    tick(8);
    frame_pulse(); #5; chk("lit_sel_010", 1, 32'(ss[1]), 32'b010);
    clean_press(); frame_pulse(); #5; chk("lit_sel_100", 1, 32'(ss[1]), 32'b100);
    clean_press(); frame_pulse(); #5; chk("lit_sel_001", 1, 32'(ss[1]), 32'b001);

    // Press event coincident with frame_start: no switch this frame
    tick(1);
    btn = 1; tick(5);
    frame = 1; tick(1);
    frame = 0; btn = 0; tick(2);
    #5;
    chk("lit_coinc_sel", 1, 32'(ss[1]), 32'b001);
    chk("lit_coinc_pend", 1, 32'(sp[1]), 32'd1);
    tick(8);
    frame_pulse(); #5; chk("lit_coinc_next", 1, 32'(ss[1]), 32'b010);

    // Second press while pending yields a single advance
    clean_press(); clean_press();
    frame_pulse(); #5; chk("lit_one_adv", 1, 32'(ss[1]), 32'b100);
    tick(3);
    frame_pulse(); #5; chk("lit_no_extra", 1, 32'(ss[1]), 32'b100);

    // Reset with a switch pending and active_src=2
    btn = 1; tick(6);
    btn = 0; tick(1);
    #5; chk("lit_pre_rst_pend", 1, 32'(sp[1]), 32'd1);
    rst = 1; tick(1);
    rst = 0; #5;
    for (int i = 0; i < NI; i++) begin
      chk("lit_rst_sel", i, 32'(ss[i]), 32'd1);
      chk("lit_rst_pend", i, 32'(sp[i]), 32'd0);
      chk("lit_rst_color", i, 32'(dc[i]), 32'd0);
    end
    tick(5);
    frame_pulse(); tick(1); #5;
    chk("lit_no_switch_after_rst", 1, 32'(ss[1]), 32'b001);

    tick(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
